instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the 9-bit instruction decoder: takes symbolic ops over valid/ready, packs 9-bit words, writes them to instr mem.
//  Sits between the program loader/test harness and the instruction memory write port.
//  Expands pseudo-op shifts >7 into two words; rejects ops the decoder cannot express.
// PARAMETERS
//  AW     8    instr-mem address width
//  DEPTH  256  usable words, DEPTH <= 2**AW
// PORTS
//  Clk        in   1   clock, all state on rising edge
//  Reset      in   1   synchronous, active-low reset
//  clear      in   1   sync restart: ptr<=0, full<=0, err_code<=0, FSM->IDLE
//  req_valid  in   1   op request valid
//  req_ready  out  1   encoder can accept this cycle
//  req_op     in   4   0 MOV,1 BR,2 SET,3 LSL,4 LSR,5 LOAD,6 STORE,7 SBF,8 ADD,9 SUB,10 AND,11 OR,12 NOT,13 XOR,14 XORB,15 illegal
//  req_a      in   4   dst reg (MOV any; LSL/LSR/ALU/XORB 0..3 => R8..RB); LOAD/STORE addr reg 0..7; SBF flag 0..4
//  req_b      in   6   MOV src[3:0]; BR/SET imm6; LSL/LSR shamt[3:0] 0..14 (0 = register-source form)
//  imem_we    out  1   write strobe, one cycle per word
//  imem_addr  out  AW  write address
//  imem_wdata out  9   encoded word
//  word_count out  AW+1  words written since clear/reset (= ptr)
//  full       out  1   ptr == DEPTH
//  err_pulse  out  1   one-cycle pulse on rejected request
//  err_code   out  2   sticky: 0 none,1 illegal op/field,2 no space
// BEHAVIOUR
//  Reset (Reset==0 at edge): state IDLE, ptr 0, all outputs 0 except req_ready 0 that cycle; err_code 0.
//  req_ready = (state==IDLE) & ~full & ~clear & Reset.
//  Encodings: MOV {0,a,b[3:0]}; BR {100,b}; SET {101,b}; LSL {110,0,a[1:0],s}; LSR {110,1,a[1:0],s};
//   LOAD {11110,0,a[2:0]}; STORE {11110,1,a[2:0]}; SBF {111011,a[2:0]};
//   ALU {1110,f,a[1:0]} f=ADD000 SUB001 AND010 OR011 NOT100 XOR101; XORB {1111100,a[1:0]}.
//  Shift expansion: shamt 0..7 -> one word s=shamt; 8..14 -> word1 s=7, word2 s=shamt-7, same dst/dir.
//  Illegal (err 1): op 15; a>3 for LSL/LSR/ALU/XORB; a>7 LOAD/STORE; a>4 SBF; shamt 15; b[5:4]!=0 MOV/LSL/LSR.
//  No space (err 2): words needed > DEPTH-ptr. Rejected req: nothing written, ptr unchanged, err_pulse 1 cycle after accept.
//  FSM: IDLE -accept ok-> EMIT1; IDLE -accept bad-> ERR; ERR -> IDLE; EMIT1 -2-word-> EMIT2 else IDLE; EMIT2 -> IDLE.
//  EMIT1/EMIT2: imem_we=1, imem_addr=ptr[AW-1:0], imem_wdata=word; ptr++ at end of cycle. Outputs registered.
//  Latency: accept at edge E0 -> word1 on bus in cycle after E0; word2 (if any) next cycle; ready again after last word.
//  Throughput: 1-word op every 2 cycles, 2-word op every 3 cycles.
//  full set when ptr reaches DEPTH; no wrap; stays until clear/reset. No partial 2-word writes ever.
//  clear has priority over everything: same edge as req -> req not accepted; during EMIT2 -> word2 dropped, ptr 0.
//  Reset mid-emit: identical to clear plus err_code 0. err_code overwritten by each new error; cleared by clear/reset.
// TESTING
//  Reset, MOV a=3 b=5 -> one cycle imem_we, addr 0, data 9'b0_0011_0101; word_count 1.
//  LSL a=2 b=12 -> addr0 9'b110_0_10_111, addr1 9'b110_0_10_101; req_ready low 2 cycles.
//  SBF a=5 -> err_pulse 1 cycle, err_code 1, no imem_we, word_count unchanged; SBF a=2 -> 9'b111011_010.
//  DEPTH=4: fill 3 words then LSR b=9 -> err_code 2, no write; then LOAD a=6 -> 9'b11110_0_110, full=1, req_ready=0.
//  clear asserted in EMIT2 of LSR b=10 -> only word1 written, ptr 0, next MOV writes addr 0.
//  Back-to-back req_valid held high: ALU SUB a=1, XORB a=3, BR b=63 -> 9'b1110_001_01, 9'b11111_00_11, 9'b100_111111 at addrs 0..2.

Source files
------------

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs symbolic ops into 9-bit words and writes them to instruction memory
module instr_encoder #(
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          clear,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_op,
    input  logic [3:0]    req_a,
    input  logic [5:0]    req_b,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [8:0]    imem_wdata,
    output logic [AW:0]   word_count,
    output logic          full,
    output logic          err_pulse,
    output logic [1:0]    err_code
);

    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2, ERR} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [8:0]    wdata_q, wdata_d;
    logic [8:0]    w2_q, w2_d;
    logic          two_q, two_d;
    logic          errp_q, errp_d;
    logic [1:0]    errc_q, errc_d;

    logic [8:0]    enc_w1, enc_w2;
    logic          enc_two, enc_bad, no_space, accept;
    logic [3:0]    shamt;
    logic [AW+1:0] need_end;
    logic [AW:0]   ptr_inc;

    assign shamt = req_b[3:0];

    always_comb begin
        enc_w1  = '0;
        enc_w2  = '0;
        enc_two = 1'b0;
        enc_bad = 1'b0;
        case (req_op)
            4'd0: begin
                enc_w1  = {1'b0, req_a, req_b[3:0]};
                enc_bad = (req_b[5:4] != 2'b00);
            end
            4'd1: enc_w1 = {3'b100, req_b};
            4'd2: enc_w1 = {3'b101, req_b};
            4'd3, 4'd4: begin
                enc_bad = (req_a > 4'd3) || (shamt == 4'd15) || (req_b[5:4] != 2'b00);
                // Shifts past 7 split into s=7 followed by the remainder (shamt-7 == low bits + 1)
                if (shamt > 4'd7) begin
                    enc_two = 1'b1;
                    enc_w1  = {3'b110, req_op == 4'd4, req_a[1:0], 3'd7};
                    enc_w2  = {3'b110, req_op == 4'd4, req_a[1:0], shamt[2:0] + 3'd1};
                end else begin
                    enc_w1  = {3'b110, req_op == 4'd4, req_a[1:0], shamt[2:0]};
                end
            end
            4'd5, 4'd6: begin
                enc_w1  = {5'b11110, req_op == 4'd6, req_a[2:0]};
                enc_bad = (req_a > 4'd7);
            end
            4'd7: begin
                enc_w1  = {6'b111011, req_a[2:0]};
                enc_bad = (req_a > 4'd4);
            end
            4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13: begin
                enc_w1  = {4'b1110, req_op[2:0], req_a[1:0]};
                enc_bad = (req_a > 4'd3);
            end
            4'd14: begin
                enc_w1  = {7'b1111100, req_a[1:0]};
                enc_bad = (req_a > 4'd3);
            end
            default: enc_bad = 1'b1;
        endcase
    end

    assign need_end  = {1'b0, ptr_q} + (enc_two ? (AW+2)'(2) : (AW+2)'(1));
    assign no_space  = need_end > (AW+2)'(DEPTH);
    assign ptr_inc   = ptr_q + 1'b1;
    assign full      = (ptr_q == (AW+1)'(DEPTH));
    assign req_ready = (state_q == IDLE) & ~full & ~clear & Reset;
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        w2_d    = w2_q;
        two_d   = two_q;
        errp_d  = 1'b0;
        errc_d  = errc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (enc_bad) begin
                        state_d = ERR;
                        errp_d  = 1'b1;
                        errc_d  = 2'd1;
                    end else if (no_space) begin
                        state_d = ERR;
                        errp_d  = 1'b1;
                        errc_d  = 2'd2;
                    end else begin
                        state_d = EMIT1;
                        we_d    = 1'b1;
                        addr_d  = ptr_q[AW-1:0];
                        wdata_d = enc_w1;
                        w2_d    = enc_w2;
                        two_d   = enc_two;
                    end
                end
            end
            EMIT1: begin
                ptr_d = ptr_inc;
                if (two_q) begin
                    state_d = EMIT2;
                    we_d    = 1'b1;
                    addr_d  = ptr_inc[AW-1:0];
                    wdata_d = w2_q;
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT2: begin
                ptr_d   = ptr_inc;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
            ptr_d   = '0;
            we_d    = 1'b0;
            errp_d  = 1'b0;
            errc_d  = 2'd0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            w2_q    <= '0;
            two_q   <= 1'b0;
            errp_q  <= 1'b0;
            errc_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            w2_q    <= w2_d;
            two_q   <= two_d;
            errp_q  <= errp_d;
            errc_q  <= errc_d;
        end
    end

    // A clear/reset landing on a write cycle suppresses that write so no partial op reaches memory
    assign imem_we    = we_q & ~clear & Reset;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = ptr_q;
    assign err_pulse  = errp_q;
    assign err_code   = errc_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder with a 4-word memory
module tb_instr_encoder;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          clear = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_op = '0;
    logic [3:0]    req_a = '0;
    logic [5:0]    req_b = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [8:0]    imem_wdata;
    logic [AW:0]   word_count;
    logic          full;
    logic          err_pulse;
    logic [1:0]    err_code;

    int tests = 0;
    int fails = 0;

    logic [AW+8:0] wq[$];
    logic [1:0]    eq[$];

    instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .full(full),
        .err_pulse(err_pulse), .err_code(err_code)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (imem_we) begin
            if (wq.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                logic [AW+8:0] e;
                e = wq.pop_front();
                check("write_addr", int'(imem_addr), int'(e[AW+8:9]));
                check("write_data", int'(imem_wdata), int'(e[8:0]));
            end
        end
        if (err_pulse) begin
            if (eq.size() == 0) begin
                check("unexpected_err", 1, 0);
            end else begin
                logic [1:0] ec;
                ec = eq.pop_front();
                check("err_code_at_pulse", int'(err_code), int'(ec));
            end
        end
    end

    task automatic exp_w(input int addr, input logic [8:0] data);
        wq.push_back({AW'(addr), data});
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [5:0] b, input bit hold);
        int n;
        n = 0;
        @(negedge Clk);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (!req_ready) check("send_timeout", 1, 0);
        @(posedge Clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge Clk);
    endtask

    task automatic do_clear();
        @(negedge Clk); clear = 1'b1;
        @(negedge Clk); clear = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset_ready", int'(req_ready), 0);
        check("reset_we", int'(imem_we), 0);
        check("reset_count", int'(word_count), 0);
        check("reset_full", int'(full), 0);
        check("reset_errc", int'(err_code), 0);
        Reset = 1'b1;

        exp_w(0, 9'b0_0011_0101);
        send(4'd0, 4'd3, 6'd5, 1'b0);
        settle();
        check("mov_count", int'(word_count), 1);

        do_clear();
        exp_w(0, 9'b110_0_10_111);
        exp_w(1, 9'b110_0_10_101);
        send(4'd3, 4'd2, 6'd12, 1'b0);
        @(negedge Clk); check("lsl_ready_c1", int'(req_ready), 0);
        @(negedge Clk); check("lsl_ready_c2", int'(req_ready), 0);
        @(negedge Clk); check("lsl_ready_c3", int'(req_ready), 1);
        check("lsl_count", int'(word_count), 2);

        eq.push_back(2'd1);
        send(4'd7, 4'd5, 6'd0, 1'b0);
        settle();
        check("sbf_bad_count", int'(word_count), 2);
        check("sbf_bad_errc", int'(err_code), 1);
        exp_w(2, 9'b111011_010);
        send(4'd7, 4'd2, 6'd0, 1'b0);
        settle();
        check("sbf_count", int'(word_count), 3);

        eq.push_back(2'd2);
        send(4'd4, 4'd1, 6'd9, 1'b0);
        settle();
        check("nospace_errc", int'(err_code), 2);
        check("nospace_count", int'(word_count), 3);
        exp_w(3, 9'b11110_0_110);
        send(4'd5, 4'd6, 6'd0, 1'b0);
        settle();
        check("load_full", int'(full), 1);
        check("load_ready", int'(req_ready), 0);
        check("load_count", int'(word_count), 4);

        do_clear();
        check("clear_errc", int'(err_code), 0);
        check("clear_full", int'(full), 0);
        exp_w(0, 9'b110_1_00_111);
        send(4'd4, 4'd0, 6'd10, 1'b0);
        @(posedge Clk); #1 clear = 1'b1;
        @(posedge Clk); #1 clear = 1'b0;
        @(negedge Clk);
        check("emit2_clear_count", int'(word_count), 0);
        exp_w(0, 9'b0_0001_0010);
        send(4'd0, 4'd1, 6'd2, 1'b0);
        settle();

        do_clear();
        exp_w(0, 9'b1110_001_01);
        exp_w(1, 9'b11111_00_11);
        exp_w(2, 9'b100_111111);
        send(4'd9, 4'd1, 6'd0, 1'b1);
        send(4'd14, 4'd3, 6'd0, 1'b1);
        send(4'd1, 4'd0, 6'd63, 1'b1);
        @(negedge Clk); req_valid = 1'b0;
        settle();
        check("b2b_count", int'(word_count), 3);

        eq.push_back(2'd1);
        send(4'd15, 4'd0, 6'd0, 1'b0);
        settle();
        check("illegal_errc", int'(err_code), 1);
        @(negedge Clk); Reset = 1'b0;
        @(negedge Clk);
        check("reset2_errc", int'(err_code), 0);
        check("reset2_count", int'(word_count), 0);
        Reset = 1'b1;
        settle();

        check("writes_outstanding", wq.size(), 0);
        check("errs_outstanding", eq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
